// File: rtl/rx_ctrl.sv
// rx_ctrl: sequencing controller for the UART receiver (rx_clock_divider + uart_rx).
// Arms/disarms the receiver, synchronises its status lines into the system clock
// domain, captures good bytes into a first-word-fall-through FIFO, and reports
// overrun, a saturating error count and an idle-gap end-of-frame pulse.
//
// Ports:
//   clk         system clock (also feeds the receiver's clock divider)
//   rst         asynchronous, active-high reset
//   cfg_enable  host request to receive (level)
//   clr_status  1-cycle pulse; clears overrun and err_count
//   rx_enable   drives receiver rx_enable
//   rx_done     receiver byte-complete (rx_clock domain)
//   rx_busy     receiver mid-frame (rx_clock domain)
//   rx_error    receiver framing error (rx_clock domain)
//   rx_data     receiver output byte, stable while rx_done is high
//   rd_valid    FIFO non-empty
//   rd_data     FIFO head byte (valid only when rd_valid=1)
//   rd_ready    host pop; pops when rd_valid & rd_ready at clk rise
//   fifo_level  current occupancy, 0..FIFO_DEPTH
//   overrun     sticky: a byte was dropped because the FIFO was full
//   err_count   saturating count of rx_error events
//   frame_end   1-cycle pulse after an idle gap following at least one byte
module rx_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 26042
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_enable,
  input  logic                          clr_status,
  output logic                          rx_enable,
  input  logic                          rx_done,
  input  logic                          rx_busy,
  input  logic                          rx_error,
  input  logic [7:0]                    rx_data,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic [7:0]                    err_count,
  output logic                          frame_end
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  state_t state, state_next;

  // Synchronisers: two flops into clk domain, third flop for edge detection.
  logic [2:0] done_sync;
  logic [2:0] err_sync;
  logic [1:0] busy_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_sync <= '0;
      err_sync  <= '0;
      busy_sync <= '0;
    end else begin
      done_sync <= {done_sync[1:0], rx_done};
      err_sync  <= {err_sync[1:0],  rx_error};
      busy_sync <= {busy_sync[0],   rx_busy};
    end
  end

  logic done_evt, err_evt, busy_s2, done_pend;
  assign done_evt  = done_sync[1] & ~done_sync[2];
  assign err_evt   = err_sync[1]  & ~err_sync[2];
  assign busy_s2   = busy_sync[1];
  // A rising rx_done still travelling through the synchroniser (or at the
  // edge detector) keeps DRAIN from closing before the byte is seen.
  assign done_pend = done_sync[0] & ~done_sync[2];

  // Error counted only while the receiver is armed; it wins over a
  // coincident done_evt, so that byte is dropped.
  logic err_hit;
  assign err_hit = err_evt & ((state == ARMED) || (state == DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_enable  = 1'b1;
    unique case (state)
      IDLE: begin
        rx_enable = 1'b0;
        if (cfg_enable) state_next = ARMED;
      end
      ARMED: begin
        if (done_evt && !err_evt) state_next = CAPTURE;
        else if (!cfg_enable)     state_next = busy_s2 ? DRAIN : IDLE;
      end
      CAPTURE: begin
        if (cfg_enable) state_next = ARMED;
        else            state_next = busy_s2 ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (done_evt && !err_evt)          state_next = CAPTURE;
        else if (!busy_s2 && !done_pend)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO: pointers one bit wider than the index so full/empty are distinct.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        push, pop, full, wr_en, ovf_set;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == (AW + 1)'(FIFO_DEPTH));
  assign rd_valid   = (fifo_level != '0);
  assign rd_data    = mem[rd_ptr[AW-1:0]];
  assign push       = (state == CAPTURE);
  assign pop        = rd_valid & rd_ready;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the write can proceed.
  assign wr_en      = push & (~full | pop);
  assign ovf_set    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Status: a set event in the same cycle as clr_status takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      if (clr_status)   overrun <= ovf_set;
      else if (ovf_set) overrun <= 1'b1;

      if (clr_status)                        err_count <= err_hit ? 8'd1 : 8'd0;
      else if (err_hit && err_count != '1)   err_count <= err_count + 8'd1;
    end
  end

  // Idle-gap timer and frame_end.
  logic [TW-1:0] idle_cnt;
  logic          got_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt  <= '0;
      got_byte  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      if (state != IDLE && state_next == IDLE) begin
        idle_cnt <= '0;
        got_byte <= 1'b0;
      end else if (state == CAPTURE) begin
        idle_cnt <= '0;
        got_byte <= 1'b1;
      end else if (busy_s2) begin
        idle_cnt <= '0;
      end else if (state == ARMED && idle_cnt != TW'(TIMEOUT_CYCLES)) begin
        idle_cnt <= idle_cnt + 1'b1;
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1) && got_byte) begin
          frame_end <= 1'b1;
          got_byte  <= 1'b0;
        end
      end
    end
  end

endmodule
